inst_fetch_aligner: RTL

// Fetch-side sequencer feeding the RVC decompressor: issues word-aligned reads to instruction

---
 rtl/inst_fetch_aligner.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_aligner.sv
// Fetch aligner: word-aligned imem reads into a 3-halfword buffer, emitting one 16- or
// 32-bit instruction per handshake with its PC; handles straddles and halfword redirects.
module inst_fetch_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        inst_is_c,
    output logic [1:0]  dbg_state,
    output logic [1:0]  dbg_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [15:0] hb   [3];
    logic [15:0] hb_n [3];
    logic [1:0]  cnt, cnt_n, cnt_pop;
    logic [31:0] buf_pc, buf_pc_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic        drop_lo, drop_lo_n;
    logic        req_n;
    logic [31:0] addr_n;
    logic        hb0_is_c;
    logic        fire;
    logic        accept;

    // Handshake: an instruction transfers on a rising edge where inst_valid && inst_ready.
    // inst_valid never depends on inst_ready, and inst_out/inst_pc/inst_is_c hold steady
    // while inst_valid is high and the transfer has not happened. A redirect in the same
    // cycle cancels the transfer.
    assign hb0_is_c   = (hb[0][1:0] != 2'b11);
    assign inst_valid = ((cnt >= 2'd1) && hb0_is_c) || (cnt >= 2'd2);
    assign inst_is_c  = inst_valid && hb0_is_c;
    assign inst_pc    = buf_pc;
    assign dbg_state  = state;
    assign dbg_cnt    = cnt;

    always_comb begin
        inst_out = 32'h0000_0000;
        if (inst_valid) begin
            if (hb0_is_c) begin
                inst_out = {16'h0000, hb[0]};
            end else begin
                inst_out = {hb[1], hb[0]};
            end
        end
    end

    assign fire   = inst_valid && inst_ready && !redirect_valid;
    assign accept = imem_rvalid && (state == S_WAIT) && !redirect_valid;

    // Fetch sequencer: one request outstanding at most, only while the buffer has room for a word.
    always_comb begin
        state_n = state;
        req_n   = 1'b0;
        addr_n  = imem_addr;
        case (state)
            S_IDLE: begin
                if (!redirect_valid && (cnt <= 2'd1)) begin
                    req_n   = 1'b1;
                    addr_n  = fetch_pc;
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_n = S_IDLE;
                end
            end
            S_FLUSH: begin
                if (imem_rvalid) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (redirect_valid) begin
            state_n = ((state != S_IDLE) && !imem_rvalid) ? S_FLUSH : S_IDLE;
        end
    end

    // Buffer update: pop the consumed instruction first, then append the returning word.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            hb_n[i] = hb[i];
        end
        cnt_pop    = cnt;
        cnt_n      = cnt;
        buf_pc_n   = buf_pc;
        fetch_pc_n = fetch_pc;
        drop_lo_n  = drop_lo;
        if (redirect_valid) begin
            cnt_n      = 2'd0;
            fetch_pc_n = {redirect_pc[31:2], 2'b00};
            buf_pc_n   = {redirect_pc[31:1], 1'b0};
            drop_lo_n  = redirect_pc[1];
        end else begin
            if (fire) begin
                if (hb0_is_c) begin
                    hb_n[0]  = hb[1];
                    hb_n[1]  = hb[2];
                    cnt_pop  = cnt - 2'd1;
                    buf_pc_n = buf_pc + 32'd2;
                end else begin
                    hb_n[0]  = hb[2];
                    cnt_pop  = cnt - 2'd2;
                    buf_pc_n = buf_pc + 32'd4;
                end
            end
            cnt_n = cnt_pop;
            if (accept) begin
                for (int i = 0; i < 3; i++) begin
                    if (2'(i) == cnt_pop) begin
                        hb_n[i] = drop_lo ? imem_rdata[31:16] : imem_rdata[15:0];
                    end else if (!drop_lo && (2'(i) == cnt_pop + 2'd1)) begin
                        hb_n[i] = imem_rdata[31:16];
                    end
                end
                cnt_n      = drop_lo ? cnt_pop + 2'd1 : cnt_pop + 2'd2;
                fetch_pc_n = fetch_pc + 32'd4;
                drop_lo_n  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= 2'd0;
            buf_pc    <= RESET_PC;
            fetch_pc  <= {RESET_PC[31:2], 2'b00};
            drop_lo   <= RESET_PC[1];
            imem_req  <= 1'b0;
            imem_addr <= {RESET_PC[31:2], 2'b00};
            for (int i = 0; i < 3; i++) begin
                hb[i] <= 16'h0000;
            end
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            buf_pc    <= buf_pc_n;
            fetch_pc  <= fetch_pc_n;
            drop_lo   <= drop_lo_n;
            imem_req  <= req_n;
            imem_addr <= addr_n;
            for (int i = 0; i < 3; i++) begin
                hb[i] <= hb_n[i];
            end
        end
    end

endmodule
